// File: rtl/dg0045_ram_arbiter.sv
// DG0045 data-RAM arbiter: the core gets combinational priority access, the host uses a four-phase req/ack handshake.
// Optional starvation statistics (stall_cnt, max_wait) are enabled with `define DG0045_ARB_STATS_EN.
module dg0045_ram_arbiter #(
    parameter int AW           = 6,
    parameter int DW           = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
`ifdef DG0045_ARB_STATS_EN
    output logic [7:0]    stall_cnt,
    output logic [7:0]    max_wait,
`endif
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        H_ACC = 2'd2,
        H_ACK = 2'd3
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          host_own;

`ifdef DG0045_ARB_STATS_EN
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] max_wait_q, max_wait_d;
`endif

    assign host_own = (state_q == H_ACC);

    // The RAM mux is combinational; reset gates the write strobe so no write can land in a reset cycle.
    always_comb begin
        if (host_own) begin
            ram_addr  = dbg_addr;
            ram_din   = dbg_wdata;
            ram_we    = dbg_we & ~reset;
            cpu_rdata = '0;
        end else begin
            ram_addr  = cpu_addr;
            ram_din   = cpu_wdata;
            ram_we    = cpu_req & cpu_we & ~reset;
            cpu_rdata = ram_dout;
        end
    end

    assign cpu_stall = host_own;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dbg_rdata_d  = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    if (cpu_req) begin
                        state_d      = WAIT;
                        starve_cnt_d = 8'd1;
                    end else begin
                        state_d = H_ACC;
                    end
                end
            end
            WAIT: begin
                if (!dbg_req) begin
                    state_d      = IDLE;
                    starve_cnt_d = '0;
                end else if (!cpu_req || (starve_cnt_q >= LIMIT)) begin
                    state_d = H_ACC;
                end else if (starve_cnt_q != 8'hFF) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
            H_ACC: begin
                state_d      = H_ACK;
                starve_cnt_d = '0;
                dbg_rdata_d  = dbg_we ? dbg_wdata : ram_dout;
            end
            H_ACK: begin
                if (!dbg_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The ack flop mirrors the next state so it falls the cycle after dbg_req drops.
        dbg_ack_d = (state_d == H_ACK);
    end

`ifdef DG0045_ARB_STATS_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        max_wait_d  = max_wait_q;
        if ((state_d == H_ACC) && (state_q != H_ACC) && cpu_req && (stall_cnt_q != 8'hFF))
            stall_cnt_d = stall_cnt_q + 8'd1;
        if ((state_q == WAIT) && (state_d == H_ACC) && (starve_cnt_q > max_wait_q))
            max_wait_d = starve_cnt_q;
    end

    assign stall_cnt = stall_cnt_q;
    assign max_wait  = max_wait_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= '0;
`ifdef DG0045_ARB_STATS_EN
            stall_cnt_q  <= '0;
            max_wait_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_ack_q    <= dbg_ack_d;
            dbg_rdata_q  <= dbg_rdata_d;
`ifdef DG0045_ARB_STATS_EN
            stall_cnt_q  <= stall_cnt_d;
            max_wait_q   <= max_wait_d;
`endif
        end
    end

endmodule
